cascaded_counter_ctrl: RTL and testbench
========================================

Name: cascaded_counter_ctrl

Overview:
Parametrised successor to the fixed 4-bit/8-bit dual counter with overflow. Two cascaded stages:
- Stage 1 is a programmable prescaler.
- Stage 2 advances once per prescaler wrap.
Both stages run on a single clock with clock enables; there is no derived clock. Adds programmable terminal counts, free-run/one-shot modes, a start/stop FSM, and a sticky overflow flag. It serves as the bit/frame timing source for the serial link logic.

Parameters:
- W1, 4, width of prescaler counter (counter1)
- W2, 8, width of main counter (counter2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; when 0, all counters hold
- start  in  1  one-cycle pulse; begin/restart counting
- stop  in  1  one-cycle pulse; abort to IDLE
- clr  in  1  synchronous clear of counter1/counter2, FSM state unchanged
- one_shot  in  1  1 = halt after first counter2 wrap; 0 = free-run
- div_i  in  W1  prescaler terminal value; period = div_i+1
- top_i  in  W2  counter2 terminal value; period = top_i+1
- ovf_ack  in  1  clears ovf_sticky
- counter1  out  W1  prescaler count
- counter2  out  W2  main count
- tick1  out  1  one-cycle pulse on prescaler wrap
- overflow2  out  1  one-cycle pulse on counter2 wrap
- ovf_sticky  out  1  set on overflow2, held until ovf_ack
- busy  out  1  1 while state == RUN

Behaviour:
- All outputs are registered. Reset values: counter1=0, counter2=0, tick1=0, overflow2=0, ovf_sticky=0, busy=0, state=IDLE.
- FSM states: IDLE, RUN, HALT.
  - IDLE --start--> RUN; counters cleared on the same edge.
  - RUN --stop--> IDLE; counters cleared.
  - RUN --(one_shot & counter2 wrap)--> HALT.
  - HALT --start--> RUN; counters cleared.
  - HALT --stop--> IDLE.
- Counting occurs only in RUN with en=1. In IDLE and HALT, tick1 and overflow2 are 0 and counters hold.
- Prescaler: if counter1 >= div_i, then counter1<=0 and tick1<=1 on that edge; else counter1<=counter1+1 and tick1<=0.
  - The >= compare makes a live decrease of div_i below the current count wrap on the next enabled edge.
  - div_i=0 gives tick1 on every enabled cycle (divide-by-1).
- counter2 advances only on edges where the prescaler wraps:
  - if counter2 >= top_i, then counter2<=0 and overflow2<=1;
  - else counter2<=counter2+1.
- With constant settings, the overflow2 period is (div_i+1)*(top_i+1) enabled cycles. The first overflow2 occurs on the (div_i+1)*(top_i+1)-th enabled RUN edge after start.
- en=0 mid-count: counters freeze and tick1/overflow2 are 0; counting resumes with no lost or extra counts.
- ovf_sticky: set when overflow2 is set; cleared by ovf_ack. If ovf_ack and a new overflow occur on the same edge, set wins (sticky=1).
- Control priority, highest first: rst > stop > start > clr > count.
  - start while already in RUN restarts from 0.
  - clr during RUN zeroes the counters and counting continues from 0 on the next enabled edge; tick1/overflow2 are 0 on the clr edge.
- one_shot is sampled at the wrap edge. On entering HALT, counter1=counter2=0, overflow2 pulses once, and busy falls on the same edge.
- rst mid-operation returns everything to reset values on the next edge, regardless of other inputs.
- No arithmetic overflow beyond the W1/W2 widths: the wrap compare always precedes the increment, so the max-value (all-ones) terminal is legal.

Decomposition:
- Package cascaded_counter_pkg holds the state enum (IDLE, RUN, HALT) and localparam defaults for W1/W2.
- One sub-module, counter_stage, is natural: parametrised width, inputs inc/clr/term, outputs count/wrap. It is instantiated twice: stage 2 inc = stage 1 wrap. The FSM, sticky flag and output pulse registers live in the top.

Test Plan:
- W1=4, W2=8, div_i=3, top_i=2, free-run, en=1, start pulse → tick1 every 4 cycles; overflow2 on enabled edges 12, 24, 36; ovf_sticky=1 after the first overflow; busy=1 throughout.
- div_i=15, top_i=255, one_shot=1 → exactly one overflow2 after 4096 cycles; busy falls on the same edge; counters read 0 and stay 0; no further tick1.
- div_i=0, top_i=0 → tick1 and overflow2 both high every enabled cycle; toggling en=0 for 5 cycles suppresses both pulses and holds counters.
- Free-run with div_i=3, top_i=2 and ovf_ack asserted on the exact overflow2 edge → ovf_sticky remains 1. A lone ovf_ack one cycle later → ovf_sticky=0.
- Mid-run at counter1=2, counter2=1: apply clr → both 0 next edge and FSM stays RUN. Later apply rst at counter2=1 → all outputs 0, busy=0, IDLE.
- In RUN with counter1=10, lower div_i from 15 to 5 → counter1 wraps to 0 with tick1 on the next enabled edge; subsequent period is 6 cycles.

Source files
------------

// File: rtl/cascaded_counter_ctrl_pkg.sv
// Shared definitions for the cascaded prescaler/main counter controller.
// Contents:
//   state_e       - controller FSM state encoding
//   W1_DEFAULT    - default prescaler width
//   W2_DEFAULT    - default main counter width
package cascaded_counter_pkg;

    localparam int unsigned W1_DEFAULT = 4;
    localparam int unsigned W2_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

endpackage

// File: rtl/cascaded_counter_ctrl_counter_stage.sv
// One stage of the cascaded counter: a wrap-at-terminal up counter.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   inc    in   advance the count on this edge
//   clr    in   synchronous clear, overrides inc
//   term   in   terminal value; the count wraps to 0 once it reaches or passes term
//   count  out  registered count
//   wrap   out  combinational: this edge wraps (inc and count >= term)
module counter_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         wrap
);

    // The >= compare (rather than ==) lets a live lowering of term below the
    // current count wrap immediately, and guarantees the increment never
    // overflows the width even when term is all ones.
    assign wrap = inc && (count >= term);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cascaded_counter_ctrl.sv
// Cascaded prescaler + main counter with start/stop FSM, one-shot mode and a
// sticky overflow flag. Single clock; stage 2 advances on stage 1 wraps.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              count enable (counters hold when 0)
//   start, stop     one-cycle control pulses (stop has priority)
//   clr             clear both counters, FSM state unchanged
//   one_shot        halt after the first counter2 wrap
//   div_i, top_i    terminal values for counter1 / counter2
//   ovf_ack         clears ovf_sticky (a same-edge overflow wins)
//   counter1/2      current counts
//   tick1           pulse on prescaler wrap
//   overflow2       pulse on counter2 wrap
//   ovf_sticky      latched overflow
//   busy            high while in RUN
module cascaded_counter_ctrl
    import cascaded_counter_pkg::*;
#(
    parameter int unsigned W1 = W1_DEFAULT,
    parameter int unsigned W2 = W2_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          stop,
    input  logic          clr,
    input  logic          one_shot,
    input  logic [W1-1:0] div_i,
    input  logic [W2-1:0] top_i,
    input  logic          ovf_ack,
    output logic [W1-1:0] counter1,
    output logic [W2-1:0] counter2,
    output logic          tick1,
    output logic          overflow2,
    output logic          ovf_sticky,
    output logic          busy
);

    state_e state;
    logic   run_cnt;
    logic   cnt_clr;
    logic   wrap1;
    logic   wrap2;

    // Any control pulse pre-empts counting for this edge. Outside RUN the
    // counters are already zero, so clearing on stop/start is harmless there.
    assign cnt_clr = stop || start || clr;
    assign run_cnt = (state == StRun) && en && !cnt_clr;

    counter_stage #(
        .W (W1)
    ) u_stage1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_cnt),
        .clr   (cnt_clr),
        .term  (div_i),
        .count (counter1),
        .wrap  (wrap1)
    );

    counter_stage #(
        .W (W2)
    ) u_stage2 (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap1),
        .clr   (cnt_clr),
        .term  (top_i),
        .count (counter2),
        .wrap  (wrap2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            busy       <= 1'b0;
            tick1      <= 1'b0;
            overflow2  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            tick1     <= wrap1;
            overflow2 <= wrap2;

            if (wrap2) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_ack) begin
                ovf_sticky <= 1'b0;
            end

            // wrap2 can only be high in RUN, so the one-shot exit needs no
            // explicit state qualifier; both counters wrap to 0 on that edge.
            if (stop) begin
                state <= StIdle;
                busy  <= 1'b0;
            end else if (start) begin
                state <= StRun;
                busy  <= 1'b1;
            end else if (wrap2 && one_shot) begin
                state <= StHalt;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cascaded_counter_ctrl.sv
module tb_cascaded_counter_ctrl;

    localparam int W1 = 4;
    localparam int W2 = 8;

    logic          clk = 1'b0;
    logic          rst, en, start, stop, clr, one_shot, ovf_ack;
    logic [W1-1:0] div_i;
    logic [W2-1:0] top_i;
    logic [W1-1:0] counter1;
    logic [W2-1:0] counter2;
    logic          tick1, overflow2, ovf_sticky, busy;

    always #5 clk = ~clk;

    cascaded_counter_ctrl #(
        .W1 (W1),
        .W2 (W2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .stop       (stop),
        .clr        (clr),
        .one_shot   (one_shot),
        .div_i      (div_i),
        .top_i      (top_i),
        .ovf_ack    (ovf_ack),
        .counter1   (counter1),
        .counter2   (counter2),
        .tick1      (tick1),
        .overflow2  (overflow2),
        .ovf_sticky (ovf_sticky),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: 0 idle, 1 run, 2 halt
    int            m_state = 0;
    int            m_c1 = 0;
    int            m_c2 = 0;
    bit            m_tick = 0, m_ovf = 0, m_sticky = 0;
    logic [15:0]   exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model with the currently driven inputs, queue its expected
    // outputs, clock the DUT and compare once the edge has settled.
    task automatic step(input string tag);
        logic [15:0] exp;
        logic [15:0] got;
        if (rst) begin
            m_state = 0; m_c1 = 0; m_c2 = 0; m_tick = 0; m_ovf = 0; m_sticky = 0;
        end else begin
            m_tick = 0;
            m_ovf  = 0;
            if (stop) begin
                m_state = 0; m_c1 = 0; m_c2 = 0;
            end else if (start) begin
                m_state = 1; m_c1 = 0; m_c2 = 0;
            end else if (clr) begin
                m_c1 = 0; m_c2 = 0;
            end else if (m_state == 1 && en) begin
                if (m_c1 >= int'(div_i)) begin
                    m_c1 = 0;
                    m_tick = 1;
                    if (m_c2 >= int'(top_i)) begin
                        m_c2 = 0;
                        m_ovf = 1;
                        if (one_shot) m_state = 2;
                    end else begin
                        m_c2 = m_c2 + 1;
                    end
                end else begin
                    m_c1 = m_c1 + 1;
                end
            end
            if (m_ovf) m_sticky = 1;
            else if (ovf_ack) m_sticky = 0;
        end
        exp_q.push_back({(m_state == 1), m_sticky, m_ovf, m_tick, m_c2[7:0], m_c1[3:0]});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = {busy, ovf_sticky, overflow2, tick1, counter2, counter1};
        check(tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step("start");
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
        one_shot = 1'b0; ovf_ack = 1'b0; div_i = 4'd3; top_i = 8'd2;

        // Reset state
        do_reset();
        check("reset_outputs", {busy, ovf_sticky, overflow2, tick1, counter2, counter1}, 32'd0);

        // Free run, div 3 / top 2: tick every 4, overflow every 12
        pulse_start();
        for (int k = 1; k <= 36; k++) begin
            step("freerun");
            check("fr_tick1", tick1, (k % 4 == 0));
            check("fr_ovf2", overflow2, (k % 12 == 0));
            check("fr_busy", busy, 1'b1);
            if (k >= 12) check("fr_sticky", ovf_sticky, 1'b1);
        end

        // ovf_ack on the overflow edge: set wins; lone ack next cycle clears
        do_reset();
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            ovf_ack = (k == 12);
            step("ack_run");
        end
        check("ack_same_edge", ovf_sticky, 1'b1);
        ovf_ack = 1'b1;
        step("ack_lone");
        ovf_ack = 1'b0;
        check("ack_clears", ovf_sticky, 1'b0);

        // clr at counter1=2, counter2=1, then rst at counter2=1
        do_reset();
        pulse_start();
        for (int k = 0; k < 6; k++) step("pre_clr");
        check("pre_clr_c1", counter1, 4'd2);
        check("pre_clr_c2", counter2, 8'd1);
        clr = 1'b1;
        step("clr");
        clr = 1'b0;
        check("clr_zero", {counter2, counter1}, 12'd0);
        check("clr_busy", busy, 1'b1);
        for (int k = 0; k < 4; k++) step("post_clr");
        check("post_clr_c2", counter2, 8'd1);
        start = 1'b1;
        do_reset();
        start = 1'b0;
        check("rst_mid", {busy, ovf_sticky, overflow2, tick1, counter2, counter1}, 32'd0);
        step("idle_hold");

        // Divide-by-1 with en gaps
        div_i = 4'd0; top_i = 8'd0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            step("div1");
            check("div1_pulses", {tick1, overflow2}, 2'b11);
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step("en_off");
            check("en_off_pulses", {tick1, overflow2}, 2'b00);
        end
        en = 1'b1;
        step("en_on");
        check("en_on_pulses", {tick1, overflow2}, 2'b11);

        // en gap mid-count with a larger divider: no lost or extra counts
        div_i = 4'd3; top_i = 8'd2;
        pulse_start();
        for (int k = 0; k < 2; k++) step("gap_a");
        en = 1'b0;
        for (int k = 0; k < 3; k++) step("gap_off");
        en = 1'b1;
        step("gap_b");
        check("gap_c1", counter1, 4'd3);

        // Live decrease of div_i at counter1=10
        do_reset();
        div_i = 4'd15; top_i = 8'd255;
        pulse_start();
        for (int k = 0; k < 10; k++) step("div_pre");
        check("div_pre_c1", counter1, 4'd10);
        div_i = 4'd5;
        step("div_lower");
        check("div_lower_wrap", {tick1, counter1}, 5'b1_0000);
        for (int k = 1; k <= 6; k++) begin
            step("div_period");
            check("div_period_tick", tick1, (k == 6));
        end

        // One-shot, full-range terminals: single overflow after 4096 edges
        do_reset();
        div_i = 4'd15; top_i = 8'd255; one_shot = 1'b1;
        pulse_start();
        for (int k = 1; k <= 4096; k++) begin
            step("oneshot");
            if (k == 4095 || k == 4096) check("os_ovf", overflow2, (k == 4096));
        end
        check("os_busy_fall", busy, 1'b0);
        check("os_counts", {counter2, counter1}, 12'd0);
        for (int k = 0; k < 20; k++) step("halt_hold");
        check("halt_quiet", {busy, overflow2, tick1, counter2, counter1}, 15'd0);
        one_shot = 1'b0;

        // HALT --start--> RUN, then stop to IDLE
        pulse_start();
        check("halt_restart", busy, 1'b1);
        step("run_again");
        stop = 1'b1;
        start = 1'b1;
        step("stop_wins");
        stop = 1'b0;
        start = 1'b0;
        check("stop_idle", {busy, counter2, counter1}, 13'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
